// File: rtl/fft_stream_iter_if.sv
// Stream bundle for fft_stream_iter: sample input, bin output, status.
// The engine is slave of the input stream and source of the output stream.
interface fft_stream_iter_if #(
  parameter int LOG2N  = 3,
  parameter int DATA_W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [2*DATA_W-1:0] in_data;
  logic                inverse;
  logic                out_valid;
  logic                out_ready;
  logic [2*DATA_W-1:0] out_data;
  logic [LOG2N-1:0]    out_index;
  logic                out_last;
  logic                busy;

  modport master (
    output in_valid, in_data, inverse, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_index, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, inverse, out_ready,
    output in_ready, out_valid, out_data,
    output out_index, out_last, busy
  );
endinterface

// File: rtl/fft_stream_iter.sv
// Iterative radix-2 DIT FFT/IFFT with one time-shared butterfly,
// per-stage 1/2 scaling, bit-reversed load and natural-order unload.
module fft_stream_iter #(
  parameter int LOG2N  = 3,
  parameter int DATA_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  fft_stream_iter_if.slave s
);
  localparam int  N      = 1 << LOG2N;
  localparam int  H      = N / 2;
  localparam int  W      = DATA_W;
  localparam int  PW     = 2 * W + 1;
  localparam real SCALE  = real'((1 << (W - 1)) - 1);
  localparam real TWO_PI = 6.283185307179586;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_t;

  typedef logic signed [W-1:0] smp_t;

  function automatic real rnd(input real x);
    return (x >= 0.0) ? $floor(x + 0.5) : -$floor(0.5 - x);
  endfunction

  function automatic logic [LOG2N-1:0] bitrev(
    input logic [LOG2N-1:0] v
  );
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  function automatic logic signed [W:0] sat_t(
    input logic signed [PW-1:0] v
  );
    logic signed [PW-1:0] hi, lo;
    hi = $signed({{(W+1){1'b0}}, {W{1'b1}}});
    lo = $signed({{(W+1){1'b1}}, {W{1'b0}}});
    if (v > hi)      return {1'b0, {W{1'b1}}};
    else if (v < lo) return {1'b1, {W{1'b0}}};
    else             return v[W:0];
  endfunction

  function automatic smp_t sat_o(
    input logic signed [W+1:0] v
  );
    logic signed [W+1:0] hi, lo;
    hi = $signed({3'b000, {(W-1){1'b1}}});
    lo = $signed({3'b111, {(W-1){1'b0}}});
    if (v > hi)      return {1'b0, {(W-1){1'b1}}};
    else if (v < lo) return {1'b1, {(W-1){1'b0}}};
    else             return v[W-1:0];
  endfunction

  state_t           r_state, w_next;
  logic [LOG2N-1:0] r_idx;
  logic [LOG2N-2:0] r_bfly;
  logic [2:0]       r_stage;
  logic             r_inv;
  smp_t             r_re [N];
  smp_t             r_im [N];

  smp_t w_twr [H];
  smp_t w_twi [H];

  // Forward-mode twiddles; the inverse sign is applied at use.
  for (genvar k = 0; k < H; k++) begin : g_tw
    localparam real ANG = TWO_PI * k / N;
    localparam int  C   = $rtoi(rnd($cos(ANG) * SCALE));
    localparam int  S   = $rtoi(rnd($sin(ANG) * SCALE));
    assign w_twr[k] = W'(C);
    assign w_twi[k] = W'(-S);
  end

  logic w_ld, w_cp, w_ul;
  logic w_in_fire, w_out_fire;
  logic w_idx_end, w_bfly_end, w_stage_end;

  assign w_ld        = (r_state == LOAD);
  assign w_cp        = (r_state == COMPUTE);
  assign w_ul        = (r_state == UNLOAD);
  assign w_in_fire   = w_ld & s.in_valid;
  assign w_out_fire  = w_ul & s.out_ready;
  assign w_idx_end   = &r_idx;
  assign w_bfly_end  = &r_bfly;
  assign w_stage_end = (r_stage == 3'(LOG2N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LOAD:    if (w_in_fire && w_idx_end)
                 w_next = COMPUTE;
      COMPUTE: if (w_bfly_end && w_stage_end)
                 w_next = UNLOAD;
      UNLOAD:  if (w_out_fire && w_idx_end)
                 w_next = LOAD;
      default: w_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_bfly  <= '0;
      r_stage <= '0;
      r_inv   <= 1'b0;
    end else begin
      if (w_in_fire || w_out_fire)
        r_idx <= r_idx + 1'b1;
      if (w_in_fire && (r_idx == '0))
        r_inv <= s.inverse;
      if (w_cp) begin
        r_bfly <= r_bfly + 1'b1;
        if (w_bfly_end)
          r_stage <= w_stage_end ? 3'd0 : r_stage + 3'd1;
      end
    end
  end

  logic [LOG2N-1:0] w_b, w_half, w_j;
  logic [LOG2N-1:0] w_a, w_bb, w_ld_addr;
  logic [LOG2N-2:0] w_k;

  always_comb begin
    w_b       = {1'b0, r_bfly};
    w_half    = (LOG2N)'(1) << r_stage;
    w_j       = w_b & (w_half - 1'b1);
    w_a       = ((w_b >> r_stage) << (r_stage + 3'd1)) | w_j;
    w_bb      = w_a | w_half;
    w_k       = (LOG2N-1)'(w_j << (3'(LOG2N - 1) - r_stage));
    w_ld_addr = bitrev(r_idx);
  end

  smp_t                w_ar, w_ai, w_br, w_bi, w_wr, w_wi;
  logic signed [PW-1:0] w_pr, w_pi;
  logic signed [W:0]    w_tr, w_ti;
  logic signed [W+1:0]  w_sr, w_si, w_dr, w_di;
  smp_t                w_xr, w_xi, w_yr, w_yi;

  always_comb begin
    w_ar = r_re[w_a];
    w_ai = r_im[w_a];
    w_br = r_re[w_bb];
    w_bi = r_im[w_bb];
    w_wr = w_twr[w_k];
    w_wi = r_inv ? -w_twi[w_k] : w_twi[w_k];
    w_pr = PW'(w_br) * PW'(w_wr) - PW'(w_bi) * PW'(w_wi);
    w_pi = PW'(w_br) * PW'(w_wi) + PW'(w_bi) * PW'(w_wr);
    // Unit twiddle passes B through untouched to keep k=0 exact.
    if (w_k == '0) begin
      w_tr = (W+1)'(w_br);
      w_ti = (W+1)'(w_bi);
    end else begin
      w_tr = sat_t(w_pr >>> (W - 1));
      w_ti = sat_t(w_pi >>> (W - 1));
    end
    w_sr = (W+2)'(w_ar) + (W+2)'(w_tr);
    w_si = (W+2)'(w_ai) + (W+2)'(w_ti);
    w_dr = (W+2)'(w_ar) - (W+2)'(w_tr);
    w_di = (W+2)'(w_ai) - (W+2)'(w_ti);
    w_xr = sat_o(w_sr >>> 1);
    w_xi = sat_o(w_si >>> 1);
    w_yr = sat_o(w_dr >>> 1);
    w_yi = sat_o(w_di >>> 1);
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_re[w_ld_addr] <= s.in_data[2*W-1:W];
      r_im[w_ld_addr] <= s.in_data[W-1:0];
    end else if (w_cp) begin
      r_re[w_a]  <= w_xr;
      r_im[w_a]  <= w_xi;
      r_re[w_bb] <= w_yr;
      r_im[w_bb] <= w_yi;
    end
  end

  always_comb begin
    s.in_ready  = 1'b0;
    s.out_valid = 1'b0;
    s.out_last  = 1'b0;
    s.busy      = 1'b0;
    s.out_index = '0;
    s.out_data  = '0;
    unique case (r_state)
      LOAD:    s.in_ready = 1'b1;
      COMPUTE: s.busy = 1'b1;
      UNLOAD: begin
        s.out_valid = 1'b1;
        s.busy      = 1'b1;
        s.out_index = r_idx;
        s.out_last  = w_idx_end;
        s.out_data  = {r_re[r_idx], r_im[r_idx]};
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fft_stream_iter.sv
// Scoreboard bench for fft_stream_iter: directed 8-point frames plus
// 64-point frames checked against a bit-true software model.
module tb_fft_stream_iter;
  localparam real TWO_PI = 6.283185307179586;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_stream_iter_if #(.LOG2N(3), .DATA_W(16)) s8 ();
  fft_stream_iter_if #(.LOG2N(6), .DATA_W(16)) s64 ();

  fft_stream_iter #(.LOG2N(3), .DATA_W(16)) dut8 (
    .clk (clk),
    .rst (rst),
    .s   (s8.slave)
  );

  fft_stream_iter #(.LOG2N(6), .DATA_W(16)) dut64 (
    .clk (clk),
    .rst (rst),
    .s   (s64.slave)
  );

  typedef struct {
    int re;
    int im;
    int idx;
    bit last;
    int tol;
  } exp_t;

  exp_t q8[$];
  exp_t q64[$];
  int   errs   = 0;
  int   checks = 0;
  int   stall_bin = -1;

  int xr8[8], xi8[8], er8[8], ei8[8];
  int xr64[64], xi64[64], mr64[64], mi64[64];

  function automatic int hre(input logic [31:0] d);
    return int'($signed(d[31:16]));
  endfunction

  function automatic int him(input logic [31:0] d);
    return int'($signed(d[15:0]));
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp, input int tol);
    longint d;
    checks++;
    d = longint'(act) - longint'(exp);
    if (d > tol || -d > tol) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)",
               nm, act, exp, tol);
    end
  endtask

  // Output-side scoreboard, 8-point engine; also checks hold under stall.
  initial begin : mon8
    exp_t e;
    bit   held;
    int   hr, hi, hx;
    held = 0;
    forever begin
      @(negedge clk);
      if (rst || !s8.out_valid) begin
        held = 0;
      end else begin
        if (held) begin
          chk("hold_re", hre(s8.out_data), hr, 0);
          chk("hold_im", him(s8.out_data), hi, 0);
          chk("hold_idx", int'(s8.out_index), hx, 0);
        end
        if (s8.out_ready) begin
          held = 0;
          if (q8.size() == 0) begin
            chk("extra_beat8", int'(s8.out_index), -1, 0);
          end else begin
            e = q8.pop_front();
            chk("re8", hre(s8.out_data), e.re, e.tol);
            chk("im8", him(s8.out_data), e.im, e.tol);
            chk("idx8", int'(s8.out_index), e.idx, 0);
            chk("last8", int'(s8.out_last), int'(e.last), 0);
          end
        end else begin
          held = 1;
          hr = hre(s8.out_data);
          hi = him(s8.out_data);
          hx = int'(s8.out_index);
        end
      end
    end
  end

  initial begin : mon64
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && s64.out_valid && s64.out_ready) begin
        if (q64.size() == 0) begin
          chk("extra_beat64", int'(s64.out_index), -1, 0);
        end else begin
          e = q64.pop_front();
          chk("re64", hre(s64.out_data), e.re, 0);
          chk("im64", him(s64.out_data), e.im, 0);
          chk("idx64", int'(s64.out_index), e.idx, 0);
          chk("last64", int'(s64.out_last), int'(e.last), 0);
        end
      end
    end
  end

  initial begin : stall8
    s8.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_bin >= 0 && s8.out_valid &&
          int'(s8.out_index) == stall_bin) begin
        stall_bin = -1;
        s8.out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        s8.out_ready = 1'b1;
      end
    end
  end

  task automatic push8(input int tol);
    for (int k = 0; k < 8; k++)
      q8.push_back('{re: er8[k], im: ei8[k], idx: k,
                     last: (k == 7), tol: tol});
  endtask

  task automatic send8(input bit inv, input bit gaps);
    chk("in_ready_load", int'(s8.in_ready), 1, 0);
    for (int n = 0; n < 8; n++) begin
      if (gaps && n[0]) begin
        s8.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
      end
      s8.in_valid = 1'b1;
      s8.in_data  = {16'(xr8[n]), 16'(xi8[n])};
      s8.inverse  = (n == 0) ? inv : ~inv;
      @(posedge clk);
      #1;
    end
    s8.in_valid = 1'b0;
  endtask

  task automatic lat8(input bit junk);
    int n;
    n = 0;
    chk("in_ready_drop", int'(s8.in_ready), 0, 0);
    chk("busy_compute", int'(s8.busy), 1, 0);
    while (!s8.out_valid && n < 100) begin
      s8.in_valid = junk && (n < 4);
      s8.in_data  = 32'h7fff8001;
      @(posedge clk);
      #1;
      n++;
    end
    s8.in_valid = 1'b0;
    chk("latency", n, 12, 0);
  endtask

  task automatic drain8();
    int n;
    n = 0;
    while ((q8.size() != 0 || s8.out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain8_left", q8.size(), 0, 0);
    chk("in_ready_back", int'(s8.in_ready), 1, 0);
  endtask

  task automatic run8(input bit inv, input bit gaps,
                      input bit junk, input int tol);
    push8(tol);
    send8(inv, gaps);
    lat8(junk);
    drain8();
  endtask

  function automatic real rnd(input real x);
    return (x >= 0.0) ? $floor(x + 0.5) : -$floor(0.5 - x);
  endfunction

  function automatic longint clip(input longint v,
                                  input longint lo, input longint hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic int brev6(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 6; i++) r |= ((v >> i) & 1) << (5 - i);
    return r;
  endfunction

  // Textbook in-place DIT on integers with the engine's rounding rules.
  task automatic model64(input bit inv);
    int     half, j, a, bb, k, wr, wi;
    longint pr, pi, tr, ti;
    for (int n = 0; n < 64; n++) begin
      mr64[brev6(n)] = xr64[n];
      mi64[brev6(n)] = xi64[n];
    end
    for (int st = 0; st < 6; st++) begin
      half = 1 << st;
      for (int b = 0; b < 32; b++) begin
        j  = b % half;
        a  = (b / half) * 2 * half + j;
        bb = a + half;
        k  = j * (64 / (2 * half));
        wr = $rtoi(rnd($cos(TWO_PI * k / 64) * 32767.0));
        wi = -$rtoi(rnd($sin(TWO_PI * k / 64) * 32767.0));
        if (inv) wi = -wi;
        if (k == 0) begin
          tr = mr64[bb];
          ti = mi64[bb];
        end else begin
          pr = longint'(mr64[bb]) * wr - longint'(mi64[bb]) * wi;
          pi = longint'(mr64[bb]) * wi + longint'(mi64[bb]) * wr;
          tr = clip(pr >>> 15, -65536, 65535);
          ti = clip(pi >>> 15, -65536, 65535);
        end
        pr = mr64[a];
        pi = mi64[a];
        mr64[a]  = int'(clip((pr + tr) >>> 1, -32768, 32767));
        mi64[a]  = int'(clip((pi + ti) >>> 1, -32768, 32767));
        mr64[bb] = int'(clip((pr - tr) >>> 1, -32768, 32767));
        mi64[bb] = int'(clip((pi - ti) >>> 1, -32768, 32767));
      end
    end
  endtask

  task automatic run64(input bit inv);
    int n;
    for (int i = 0; i < 64; i++) begin
      xr64[i] = int'($urandom_range(0, 65535)) - 32768;
      xi64[i] = int'($urandom_range(0, 65535)) - 32768;
    end
    model64(inv);
    for (int i = 0; i < 64; i++)
      q64.push_back('{re: mr64[i], im: mi64[i], idx: i,
                      last: (i == 63), tol: 0});
    for (int i = 0; i < 64; i++) begin
      s64.in_valid = 1'b1;
      s64.in_data  = {16'(xr64[i]), 16'(xi64[i])};
      s64.inverse  = (i == 0) ? inv : ~inv;
      @(posedge clk);
      #1;
    end
    s64.in_valid = 1'b0;
    n = 0;
    while ((q64.size() != 0 || s64.out_valid) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain64_left", q64.size(), 0, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1;
    s8.in_valid  = 1'b0;
    s8.in_data   = '0;
    s8.inverse   = 1'b0;
    s64.in_valid = 1'b0;
    s64.in_data  = '0;
    s64.inverse  = 1'b0;
    s64.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", int'(s8.in_ready), 1, 0);
    chk("rst_out_valid", int'(s8.out_valid), 0, 0);
    chk("rst_busy", int'(s8.busy), 0, 0);
    chk("rst_out_last", int'(s8.out_last), 0, 0);
    chk("rst_out_index", int'(s8.out_index), 0, 0);
    chk("rst_out_data", int'(s8.out_data), 0, 0);
    chk("rst64_in_ready", int'(s64.in_ready), 1, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    xr8 = '{1000, 0, 0, 0, 0, 0, 0, 0};
    xi8 = '{0, 0, 0, 0, 0, 0, 0, 0};
    er8 = '{125, 125, 125, 125, 125, 125, 125, 125};
    ei8 = '{0, 0, 0, 0, 0, 0, 0, 0};
    run8(1'b0, 1'b0, 1'b0, 0);

    xr8 = '{800, 800, 800, 800, 800, 800, 800, 800};
    er8 = '{800, 0, 0, 0, 0, 0, 0, 0};
    run8(1'b0, 1'b0, 1'b0, 0);

    xr8 = '{800, -800, 800, -800, 800, -800, 800, -800};
    er8 = '{0, 0, 0, 0, 800, 0, 0, 0};
    run8(1'b0, 1'b0, 1'b0, 0);

    xr8 = '{0, 8000, 0, 0, 0, 0, 0, 0};
    er8 = '{1000, 707, 0, -707, -1000, -707, 0, 707};
    ei8 = '{0, -707, -1000, -707, 0, 707, 1000, 707};
    stall_bin = 2;
    run8(1'b0, 1'b0, 1'b1, 2);

    ei8 = '{0, 707, 1000, 707, 0, -707, -1000, -707};
    run8(1'b1, 1'b1, 1'b0, 2);

    xr8 = '{-32768, -32768, -32768, -32768,
            -32768, -32768, -32768, -32768};
    xi8 = xr8;
    er8 = '{-32768, 0, 0, 0, 0, 0, 0, 0};
    ei8 = '{-32768, 0, 0, 0, 0, 0, 0, 0};
    run8(1'b0, 1'b0, 1'b0, 0);

    xr8 = '{1000, 0, 0, 0, 0, 0, 0, 0};
    xi8 = '{0, 0, 0, 0, 0, 0, 0, 0};
    send8(1'b0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    chk("pre_abort_busy", int'(s8.busy), 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", int'(s8.out_valid), 0, 0);
    chk("abort_in_ready", int'(s8.in_ready), 1, 0);
    chk("abort_busy", int'(s8.busy), 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    er8 = '{125, 125, 125, 125, 125, 125, 125, 125};
    ei8 = '{0, 0, 0, 0, 0, 0, 0, 0};
    run8(1'b0, 1'b0, 1'b0, 0);

    run64(1'b0);
    run64(1'b1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
